// File: rtl/different_dff.sv
// different_dff: no-reset, sync-reset and async-reset flops on one d_i; DIFF_DFF_CE_EN adds clock enable en_i
module different_dff #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
`ifdef DIFF_DFF_CE_EN
  input  logic             en_i,
`endif
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_norst_o,
  output logic [WIDTH-1:0] q_syncrst_o,
  output logic [WIDTH-1:0] q_asyncrst_o
);
  logic en;
`ifdef DIFF_DFF_CE_EN
  assign en = en_i;
`else
  assign en = 1'b1;
`endif
  always_ff @(posedge clk)
    if (en) q_norst_o <= d_i;
  always_ff @(posedge clk)
    if (reset) q_syncrst_o <= RESET_VAL;
    else if (en) q_syncrst_o <= d_i;
  always_ff @(posedge clk or posedge reset)
    if (reset) q_asyncrst_o <= RESET_VAL;
    else if (en) q_asyncrst_o <= d_i;
endmodule

// File: tb/tb_different_dff.sv
// tb_different_dff: random and directed stimulus against a per-edge behavioural model of the three flops
module tb_different_dff;
  localparam int W = 4;
  localparam logic [W-1:0] RV = '0;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [W-1:0] d_i = '0;
  logic [W-1:0] q_norst_o, q_syncrst_o, q_asyncrst_o;
  logic [W-1:0] m_norst, m_sync, m_async;
  logic [19:0] pat;
  int checks = 0;
  int errors = 0;
  different_dff #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk),
    .reset(reset),
    .d_i(d_i),
    .q_norst_o(q_norst_o),
    .q_syncrst_o(q_syncrst_o),
    .q_asyncrst_o(q_asyncrst_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic [W-1:0] d, input logic r);
    logic was_r;
    @(negedge clk);
    was_r = reset;
    d_i = d;
    #1 reset = r;
    #1;
    if (r && !was_r) begin
      check("async_clear", q_asyncrst_o, RV);
      check("sync_wait", q_syncrst_o, m_sync);
      check("norst_wait", q_norst_o, m_norst);
    end
    @(posedge clk);
    m_norst = d;
    m_sync  = r ? RV : d;
    m_async = r ? RV : d;
    #1;
    check("norst", q_norst_o, m_norst);
    check("syncrst", q_syncrst_o, m_sync);
    check("asyncrst", q_asyncrst_o, m_async);
  endtask
  initial begin
    m_norst = '0; m_sync = '0; m_async = '0;
    step('0, 1'b0);
    repeat (3) step('0, 1'b1);
    step('0, 1'b0);
    pat = 20'b00000111110000011111;
    for (int i = 0; i < 20; i++) step({W{pat[i]}}, 1'b0);
    for (int i = 0; i < 20; i++) step({W{pat[i]}}, i >= 13);
    step('1, 1'b0);
    step('1, 1'b0);
    step('1, 1'b1);
    step('1, 1'b0);
    for (int i = 0; i < 200; i++) step(W'($urandom), $urandom_range(0, 4) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
